// File: rtl/wb_uart_pkg.sv
// Shared definitions for the Wishbone UART transmitter: register offsets,
// STATUS bit positions, serialiser state encoding and the divider floor.
package wb_uart_pkg;

   localparam logic [3:0] REG_DATA   = 4'h0;
   localparam logic [3:0] REG_STATUS = 4'h4;
   localparam logic [3:0] REG_DIV    = 4'h8;
   localparam logic [3:0] REG_CTRL   = 4'hC;

   localparam int ST_FULL    = 0;
   localparam int ST_EMPTY   = 1;
   localparam int ST_BUSY    = 2;
   localparam int ST_OVF     = 3;
   localparam int ST_CNT_LSB = 4;
   localparam int ST_CNT_MSB = 8;

   localparam logic [15:0] DIV_MIN = 16'd2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } tx_state_t;

   // Divider values below two cannot time a bit, so they are lifted to two.
   function automatic logic [15:0] eff_div(input logic [15:0] i_div);
      logic [15:0] w_res;
      if (i_div < DIV_MIN) begin
         w_res = DIV_MIN;
      end else begin
         w_res = i_div;
      end
      return w_res;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte-wide synchronous FIFO feeding the UART serialiser.
// A push while full is ignored (the caller flags overflow); push and pop in
// the same cycle both take effect and leave the count unchanged.
module uart_tx_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic [7:0]                 i_din,
   output logic [7:0]                 o_dout,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);
   import wb_uart_pkg::*;

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [CW-1:0] r_cnt;
   logic          w_full;
   logic          w_empty;
   logic          w_do_push;
   logic          w_do_pop;

   assign w_full    = (r_cnt == FULL_CNT);
   assign w_empty   = (r_cnt == {CW{1'b0}});
   assign w_do_push = i_push & ~w_full;
   assign w_do_pop  = i_pop & ~w_empty;

   // Storage array: written on an accepted push, never reset.
   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[r_wr] <= i_din;
      end
   end

   // Pointers and occupancy count.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr  <= {AW{1'b0}};
         r_rd  <= {AW{1'b0}};
         r_cnt <= {CW{1'b0}};
      end else begin
         if (w_do_push) begin
            r_wr <= r_wr + AW'(1);
         end
         if (w_do_pop) begin
            r_rd <= r_rd + AW'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign o_dout  = r_mem[r_rd];
   assign o_full  = w_full;
   assign o_empty = w_empty;
   assign o_count = r_cnt;

endmodule

// File: rtl/wb_uart_tx.sv
// Wishbone-slave 8N1 UART transmitter: bus decode, DATA/STATUS/DIV/CTRL
// registers, baud counter and frame FSM driving one user IO pad.
// Optional macro WB_UART_TX_IRQ_EN adds a transmit-complete level interrupt
// and the CTRL[1] irq_en bit; without it irq_o is tied low.
module wb_uart_tx
   import wb_uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        tx_o,
   output logic        tx_oeb_o,
   output logic        irq_o
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic            r_ack;
   logic [31:0]     r_dat;
   logic [15:0]     r_div;
   logic            r_tx_en;
   logic            r_ovf;
   tx_state_t       r_state;
   logic [15:0]     r_cnt;
   logic [15:0]     r_div_lat;
   logic [2:0]      r_bit;
   logic [7:0]      r_shift;
   logic            r_tx;

   logic            w_hit;
   logic            w_acc;
   logic            w_wr;
   logic            w_rd;
   logic            w_push;
   logic            w_pop;
   logic            w_full;
   logic            w_empty;
   logic [CW-1:0]   w_count;
   logic [7:0]      w_dout;
   logic            w_bit_end;
   logic            w_busy;
   logic            w_irq_en;
   logic [31:0]     w_status;
   logic [31:0]     w_rdata;
   logic            w_unused;

   // Only part of the write data and byte selects carry register bits.
   assign w_unused = &{1'b0, wbs_sel_i, wbs_dat_i};

   assign w_hit  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
   assign w_acc  = w_hit & ~r_ack;
   assign w_wr   = w_acc & wbs_we_i;
   assign w_rd   = w_acc & ~wbs_we_i;
   assign w_push = w_wr & (wbs_adr_i[3:0] == REG_DATA) & wbs_sel_i[0];
   assign w_busy = (r_state != S_IDLE);
   assign w_bit_end = (r_cnt == (r_div_lat - 16'd1));

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (wb_clk_i),
      .i_rst   (wb_rst_i),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_din   (wbs_dat_i[7:0]),
      .o_dout  (w_dout),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // STATUS word assembled from FIFO flags, FSM activity and the sticky overflow.
   always_comb begin
      w_status = 32'd0;
      w_status[ST_FULL]  = w_full;
      w_status[ST_EMPTY] = w_empty;
      w_status[ST_BUSY]  = w_busy;
      w_status[ST_OVF]   = r_ovf;
      w_status[ST_CNT_MSB:ST_CNT_LSB] = 5'(w_count);
   end

   // Read data multiplexer by register offset; unmapped offsets read zero.
   always_comb begin
      w_rdata = 32'd0;
      case (wbs_adr_i[3:0])
         REG_DATA:   w_rdata = 32'd0;
         REG_STATUS: w_rdata = w_status;
         REG_DIV:    w_rdata = {16'd0, r_div};
         REG_CTRL:   w_rdata = {30'd0, w_irq_en, r_tx_en};
         default:    w_rdata = 32'd0;
      endcase
   end

   // Pop a byte when a new frame starts, from IDLE or straight out of STOP.
   always_comb begin
      w_pop = 1'b0;
      if (r_tx_en && !w_empty) begin
         if (r_state == S_IDLE) begin
            w_pop = 1'b1;
         end else if ((r_state == S_STOP) && w_bit_end) begin
            w_pop = 1'b1;
         end else begin
            w_pop = 1'b0;
         end
      end else begin
         w_pop = 1'b0;
      end
   end

   // Bus acknowledge pulse and registered read data, valid only with ack.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_ack <= 1'b0;
         r_dat <= 32'd0;
      end else begin
         r_ack <= w_acc;
         r_dat <= w_rd ? w_rdata : 32'd0;
      end
   end

   // DIV and tx_en registers, written in the accepted bus cycle.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_div   <= DEFAULT_DIV;
         r_tx_en <= 1'b0;
      end else begin
         if (w_wr && (wbs_adr_i[3:0] == REG_DIV)) begin
            if (wbs_sel_i[0]) begin
               r_div[7:0] <= wbs_dat_i[7:0];
            end
            if (wbs_sel_i[1]) begin
               r_div[15:8] <= wbs_dat_i[15:8];
            end
         end
         if (w_wr && (wbs_adr_i[3:0] == REG_CTRL) && wbs_sel_i[0]) begin
            r_tx_en <= wbs_dat_i[0];
         end
      end
   end

   // Sticky overflow: set by a push into a full FIFO, cleared by a STATUS read.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_ovf <= 1'b0;
      end else if (w_push && w_full) begin
         r_ovf <= 1'b1;
      end else if (w_rd && (wbs_adr_i[3:0] == REG_STATUS)) begin
         r_ovf <= 1'b0;
      end
   end

   // Frame FSM with baud counter; DIV is sampled once per frame at START entry.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_state   <= S_IDLE;
         r_cnt     <= 16'd0;
         r_div_lat <= eff_div(DEFAULT_DIV);
         r_bit     <= 3'd0;
         r_shift   <= 8'd0;
         r_tx      <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_cnt <= 16'd0;
               if (w_pop) begin
                  r_state   <= S_START;
                  r_shift   <= w_dout;
                  r_div_lat <= eff_div(r_div);
                  r_tx      <= 1'b0;
               end else begin
                  r_tx <= 1'b1;
               end
            end
            S_START: begin
               if (w_bit_end) begin
                  r_cnt   <= 16'd0;
                  r_bit   <= 3'd0;
                  r_state <= S_DATA;
                  r_tx    <= r_shift[0];
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  r_cnt <= 16'd0;
                  if (r_bit == 3'd7) begin
                     r_state <= S_STOP;
                     r_tx    <= 1'b1;
                  end else begin
                     r_bit   <= r_bit + 3'd1;
                     r_shift <= {1'b0, r_shift[7:1]};
                     r_tx    <= r_shift[1];
                  end
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_STOP: begin
               if (w_bit_end) begin
                  r_cnt <= 16'd0;
                  if (w_pop) begin
                     r_state   <= S_START;
                     r_shift   <= w_dout;
                     r_div_lat <= eff_div(r_div);
                     r_tx      <= 1'b0;
                  end else begin
                     r_state <= S_IDLE;
                     r_tx    <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= 16'd0;
               r_tx    <= 1'b1;
            end
         endcase
      end
   end

`ifdef WB_UART_TX_IRQ_EN
   logic r_irq_en;
   logic r_irq;

   // irq_en control bit.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_irq_en <= 1'b0;
      end else if (w_wr && (wbs_adr_i[3:0] == REG_CTRL) && wbs_sel_i[0]) begin
         r_irq_en <= wbs_dat_i[1];
      end
   end

   // Transmit-complete level interrupt: nothing queued and serialiser idle.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= r_irq_en & w_empty & ~w_busy;
      end
   end

   assign w_irq_en = r_irq_en;
   assign irq_o    = r_irq;
`else
   assign w_irq_en = 1'b0;
   assign irq_o    = 1'b0;
`endif

   assign wbs_ack_o = r_ack;
   assign wbs_dat_o = r_dat;
   assign tx_o      = r_tx;
   assign tx_oeb_o  = 1'b0;

endmodule

// File: tb/tb_wb_uart_tx.sv
// Self-checking bench for wb_uart_tx. Serial output is logged every clock and
// compared against an 8N1 waveform built from the queued bytes and divider.
module tb_wb_uart_tx;

   localparam logic [31:0] BASE = 32'h3000_0000;
   localparam logic [3:0]  O_DATA = 4'h0, O_STATUS = 4'h4, O_DIV = 4'h8, O_CTRL = 4'hC;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [3:0]  sel = 4'h0;
   logic [31:0] adr = 32'd0, wdat = 32'd0;
   logic        ack, tx, oeb, irq;
   logic [31:0] rdat;

   int total = 0;
   int bad   = 0;
   logic tx_log[$];
   bit   logging = 1'b0;

   wb_uart_tx dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .wbs_cyc_i (cyc),
      .wbs_stb_i (stb),
      .wbs_we_i  (we),
      .wbs_sel_i (sel),
      .wbs_adr_i (adr),
      .wbs_dat_i (wdat),
      .wbs_ack_o (ack),
      .wbs_dat_o (rdat),
      .tx_o      (tx),
      .tx_oeb_o  (oeb),
      .irq_o     (irq)
   );

   always #5 clk = ~clk;

   always begin
      @(posedge clk);
      #1;
      if (logging) tx_log.push_back(tx);
   end

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus(input logic w, input logic [3:0] off, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output int lat);
      @(posedge clk);
      #1;
      cyc = 1'b1; stb = 1'b1; we = w; adr = BASE | {28'd0, off}; wdat = d; sel = s;
      rd = 32'd0; lat = 0;
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk);
         #1;
         if (ack === 1'b1) begin
            lat = i;
            rd  = rdat;
            break;
         end
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      if (lat == 0) begin
         total++; bad++;
         $display("FAIL bus_ack: offset %h got no ack, wanted ack within 4 clocks", off);
      end
   endtask

   task automatic wb_write(input logic [3:0] off, input logic [31:0] d);
      logic [31:0] x;
      int l;
      bus(1'b1, off, d, 4'hF, x, l);
   endtask

   task automatic wb_read(input logic [3:0] off, output logic [31:0] d);
      int l;
      bus(1'b0, off, 32'd0, 4'hF, d, l);
   endtask

   task automatic push_byte(input logic [7:0] b);
      logic [31:0] r;
      r = $urandom();
      wb_write(O_DATA, {r[31:8], b});
   endtask

   // Reference: idle 1s, then per byte a 0 start, 8 data bits LSB first and a 1 stop,
   // each held for max(div,2) clocks, frames contiguous, then idle 1s.
   task automatic check_wave(input string name, input logic [7:0] bytes[$], input int div);
      logic exp[$];
      int eff, f, mism;
      logic lv;
      logic [7:0] b;
      eff = (div < 2) ? 2 : div;
      foreach (bytes[n]) begin
         b = bytes[n];
         for (int k = 0; k < 10; k++) begin
            lv = (k == 0) ? 1'b0 : ((k == 9) ? 1'b1 : b[k-1]);
            repeat (eff) exp.push_back(lv);
         end
      end
      f = -1;
      foreach (tx_log[i]) begin
         if (tx_log[i] === 1'b0) begin f = i; break; end
      end
      total++;
      if (f < 0) begin
         bad++;
         $display("FAIL %s_start: no start bit in %0d samples, wanted one", name, tx_log.size());
      end else begin
         mism = 0;
         for (int i = 0; i < tx_log.size(); i++) begin
            if (i < f) lv = 1'b1;
            else if (i - f < exp.size()) lv = exp[i-f];
            else lv = 1'b1;
            if (tx_log[i] !== lv) mism++;
         end
         if (f + exp.size() > tx_log.size()) mism += f + exp.size() - tx_log.size();
         if (mism != 0) begin
            bad++;
            $display("FAIL %s_wave: %0d samples differ (log %0d, start %0d), wanted 0 (div %0d, %0d bytes)",
                     name, mism, tx_log.size(), f, eff, bytes.size());
         end
      end
   endtask

   task automatic test_reset;
      logic [31:0] d;
      int lat;
      logic [3:0] pat;
      bit seen;
      wait_clks(3);
      total++;
      if ({tx, oeb, ack, irq} !== 4'b1000 || rdat !== 32'd0) begin
         bad++;
         $display("FAIL reset_out: tx/oeb/ack/irq=%b dat=%h, wanted 1000 dat=0", {tx, oeb, ack, irq}, rdat);
      end
      rst = 1'b0;
      wait_clks(1);
      // an address outside the decoded window must never be acknowledged
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h10; sel = 4'hF;
      seen = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (ack !== 1'b0) seen = 1'b1;
      end
      cyc = 1'b0; stb = 1'b0;
      total++;
      if (seen) begin bad++; $display("FAIL no_hit: ack seen=%b, wanted 0", seen); end
      bus(1'b0, O_STATUS, 32'd0, 4'hF, d, lat);
      total++;
      if (d !== 32'h0000_0002 || lat != 1) begin
         bad++;
         $display("FAIL reset_status: dat=%h lat=%0d, wanted 00000002 lat=1", d, lat);
      end
      @(posedge clk);
      #1;
      total++;
      if (ack !== 1'b0) begin bad++; $display("FAIL ack_pulse: ack=%b after pulse, wanted 0", ack); end
      // holding the strobe gives alternate-cycle acks only
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE | 32'h4;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         pat[i] = ack;
      end
      cyc = 1'b0; stb = 1'b0;
      total++;
      if (pat !== 4'b0101) begin bad++; $display("FAIL ack_hold: pattern=%b, wanted 0101", pat); end
      wb_read(O_DIV, d);
      total++;
      if (d !== 32'd868) begin bad++; $display("FAIL reset_div: %h, wanted %h", d, 32'd868); end
      wb_read(O_CTRL, d);
      total++;
      if (d !== 32'd0) begin bad++; $display("FAIL reset_ctrl: %h, wanted 0", d); end
   endtask

   task automatic test_single_frame;
      logic [31:0] d;
      logic [7:0] q[$];
      int div;
      wb_write(O_CTRL, 32'd1);
      for (int t = 0; t < 5; t++) begin
         div = (t == 0) ? 4 : int'($urandom_range(0, 6));
         q.delete();
         q.push_back((t == 0) ? 8'h55 : 8'($urandom_range(0, 255)));
         wb_write(O_DIV, div);
         tx_log.delete();
         logging = 1'b1;
         push_byte(q[0]);
         wait_clks(2);
         wb_read(O_STATUS, d);
         total++;
         if (d !== 32'h0000_0006) begin bad++; $display("FAIL frame_busy: status=%h, wanted 00000006", d); end
         wait_clks(10 * ((div < 2) ? 2 : div) + 4);
         wb_read(O_STATUS, d);
         logging = 1'b0;
         total++;
         if (d !== 32'h0000_0002) begin bad++; $display("FAIL frame_idle: status=%h, wanted 00000002", d); end
         check_wave("single", q, div);
      end
   endtask

   task automatic test_overflow;
      logic [31:0] d;
      logic [7:0] q[$];
      logic [7:0] b;
      int div;
      wb_write(O_CTRL, 32'd0);
      for (int i = 0; i < 9; i++) begin
         b = 8'($urandom_range(0, 255));
         if (i < 8) q.push_back(b);
         push_byte(b);
      end
      wb_read(O_STATUS, d);
      total++;
      if (d !== 32'h0000_0089) begin bad++; $display("FAIL ovf_status: %h, wanted 00000089", d); end
      wb_read(O_STATUS, d);
      total++;
      if (d !== 32'h0000_0081) begin bad++; $display("FAIL ovf_clear: %h, wanted 00000081", d); end
      div = int'($urandom_range(0, 3));
      wb_write(O_DIV, div);
      tx_log.delete();
      logging = 1'b1;
      wb_write(O_CTRL, 32'd1);
      wait_clks(80 * ((div < 2) ? 2 : div) + 6);
      logging = 1'b0;
      check_wave("drain", q, div);
      wb_read(O_STATUS, d);
      total++;
      if (d !== 32'h0000_0002) begin bad++; $display("FAIL drain_status: %h, wanted 00000002", d); end
   endtask

   task automatic test_back_to_back;
      logic [7:0] q[$];
      int div, n;
      for (int t = 0; t < 3; t++) begin
         q.delete();
         wb_write(O_CTRL, 32'd0);
         if (t == 0) begin
            div = 4;
            q.push_back(8'h00);
            q.push_back(8'hFF);
         end else begin
            div = int'($urandom_range(2, 5));
            n = int'($urandom_range(2, 4));
            for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
         end
         wb_write(O_DIV, div);
         foreach (q[i]) push_byte(q[i]);
         tx_log.delete();
         logging = 1'b1;
         wb_write(O_CTRL, 32'd1);
         wait_clks(10 * div * q.size() + 6);
         logging = 1'b0;
         check_wave("b2b", q, div);
      end
   endtask

   task automatic test_reset_mid;
      logic [31:0] d;
      wb_write(O_CTRL, 32'd1);
      wb_write(O_DIV, 32'd4);
      push_byte(8'h00);
      wait_clks(6);
      total++;
      if (tx !== 1'b0) begin bad++; $display("FAIL mid_pre: tx=%b in data bit, wanted 0", tx); end
      #3;
      rst = 1'b1;
      #1;
      total++;
      if (tx !== 1'b1) begin bad++; $display("FAIL mid_reset_tx: tx=%b, wanted 1", tx); end
      wait_clks(2);
      rst = 1'b0;
      wb_read(O_STATUS, d);
      total++;
      if (d !== 32'h0000_0002) begin bad++; $display("FAIL mid_status: %h, wanted 00000002", d); end
      wb_read(O_DIV, d);
      total++;
      if (d !== 32'd868) begin bad++; $display("FAIL mid_div: %h, wanted %h", d, 32'd868); end
      total++;
      if (tx !== 1'b1) begin bad++; $display("FAIL mid_idle_tx: tx=%b, wanted 1", tx); end
   endtask

   task automatic test_irq;
      logic [31:0] d;
`ifdef WB_UART_TX_IRQ_EN
      wb_write(O_DIV, 32'd2);
      wb_write(O_CTRL, 32'd3);
      wait_clks(2);
      total++;
      if (irq !== 1'b1) begin bad++; $display("FAIL irq_idle: irq=%b, wanted 1", irq); end
      push_byte(8'($urandom_range(0, 255)));
      wait_clks(2);
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear: irq=%b, wanted 0", irq); end
      wait_clks(10);
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL irq_busy: irq=%b, wanted 0", irq); end
      wait_clks(12);
      total++;
      if (irq !== 1'b1) begin bad++; $display("FAIL irq_done: irq=%b, wanted 1", irq); end
      wb_read(O_CTRL, d);
      total++;
      if (d !== 32'd3) begin bad++; $display("FAIL irq_ctrl: %h, wanted 3", d); end
`else
      wb_write(O_DIV, 32'd2);
      wb_write(O_CTRL, 32'd3);
      wb_read(O_CTRL, d);
      total++;
      if (d !== 32'd1) begin bad++; $display("FAIL ctrl_noirq: %h, wanted 1", d); end
      push_byte(8'($urandom_range(0, 255)));
      wait_clks(26);
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL irq_tied: irq=%b, wanted 0", irq); end
`endif
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_overflow();
      test_back_to_back();
      test_reset_mid();
      test_irq();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
